// File: rtl/emulate_pull_resistor.sv
`default_nettype none
// ============================================================================
// Module   : emulate_pull_resistor
// Purpose  : Emulates pull-up / pull-down resistors on bidirectional pads that
//            have no physical pulls. Each period the pads are briefly driven to
//            the selected pull level, released, allowed to settle, and then
//            sampled. Any external driver overrides the emulated pull after
//            release. Samples pass through a per-channel consecutive-sample
//            filter before reaching the registered output.
// Ports    : clk          - single clock, rising edge
//            rst          - asynchronous active-high reset
//            pad          - [SIZE] bidirectional pins (driven or high-Z)
//            pull_mode    - [2*SIZE] per channel: 00 none, 01 down, 10 up,
//                           11 none
//            out          - [SIZE] filtered, registered pad values
//            sample_valid - one-cycle pulse after every sample commit
//            changed      - one-cycle pulse with sample_valid when any out
//                           bit changed at that commit
// Revision : 1.0 - initial release
// ============================================================================
module emulate_pull_resistor #(
  parameter int              SIZE          = 8,
  parameter int              DRIVE_CYCLES  = 1,
  parameter int              SETTLE_CYCLES = 2,
  parameter int              SAMPLE_CYCLES = 1,
  parameter int              FILTER        = 2,
  parameter logic [SIZE-1:0] RESET_VAL     = {SIZE{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [SIZE-1:0]   pad,
  input  logic [2*SIZE-1:0] pull_mode,
  output logic [SIZE-1:0]   out,
  output logic              sample_valid,
  output logic              changed
);

  // One phase counter serves all states, so it is sized for the longest one.
  localparam int c_MAX_LEN =
    (DRIVE_CYCLES > SETTLE_CYCLES)
      ? ((DRIVE_CYCLES  > SAMPLE_CYCLES) ? DRIVE_CYCLES  : SAMPLE_CYCLES)
      : ((SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES);
  localparam int c_PW = (c_MAX_LEN > 1) ? $clog2(c_MAX_LEN) : 1;

  localparam logic [c_PW-1:0] c_DRIVE_LAST  = c_PW'(DRIVE_CYCLES  - 1);
  localparam logic [c_PW-1:0] c_SETTLE_LAST = c_PW'(SETTLE_CYCLES - 1);
  localparam logic [c_PW-1:0] c_SAMPLE_LAST = c_PW'(SAMPLE_CYCLES - 1);
  localparam logic [3:0]      c_FILTER      = 4'(FILTER);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_SAMPLE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_PW-1:0]     r_phase;
  logic [c_PW-1:0]     w_phase_nxt;
  logic                w_enter_drive;
  logic                w_commit;

  logic [2*SIZE-1:0]   r_mode;
  logic [SIZE-1:0]     r_sync1;
  logic [SIZE-1:0]     r_sync2;
  logic [SIZE-1:0]     r_out;
  logic [SIZE-1:0]     w_out_nxt;
  logic [SIZE-1:0]     w_upd;
  logic [3:0]          r_cnt     [SIZE];
  logic [3:0]          w_cnt_nxt [SIZE];
  logic                r_sample_valid;
  logic                r_changed;

  // --------------------------------------------------------------------------
  // Sequencer: IDLE -> DRIVE -> SETTLE -> SAMPLE -> DRIVE ...
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase + 1'b1;
    w_enter_drive = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt   = S_DRIVE;
        w_phase_nxt   = '0;
        w_enter_drive = 1'b1;
      end
      S_DRIVE: begin
        if (r_phase == c_DRIVE_LAST) begin
          w_state_nxt = S_SETTLE;
          w_phase_nxt = '0;
        end
      end
      S_SETTLE: begin
        if (r_phase == c_SETTLE_LAST) begin
          w_state_nxt = S_SAMPLE;
          w_phase_nxt = '0;
        end
      end
      S_SAMPLE: begin
        if (r_phase == c_SAMPLE_LAST) begin
          w_state_nxt   = S_DRIVE;
          w_phase_nxt   = '0;
          w_enter_drive = 1'b1;
          w_commit      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Mode register: sampled only when a period starts so a period never sees a
  // mix of old and new modes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= '0;
    end else if (w_enter_drive) begin
      r_mode <= pull_mode;
    end
  end

  // --------------------------------------------------------------------------
  // Pad drivers. Mode 01 drives 0 and 10 drives 1, which is exactly the upper
  // mode bit; 00 and 11 leave the pad floating. Since state and mode both
  // reset asynchronously, reset releases the pads without waiting for clk.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_pad
      logic w_oe;
      assign w_oe    = (r_state == S_DRIVE) &&
                       (r_mode[2*gi +: 2] == 2'b01 || r_mode[2*gi +: 2] == 2'b10);
      assign pad[gi] = w_oe ? r_mode[2*gi+1] : 1'bz;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Two-flop synchroniser, free running.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pad;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel filter: a sample equal to the current output clears progress;
  // a differing sample advances it, and reaching FILTER adopts the sample.
  // --------------------------------------------------------------------------
  always_comb begin
    w_out_nxt = r_out;
    w_upd     = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_commit) begin
        if (r_sync2[i] == r_out[i]) begin
          w_cnt_nxt[i] = '0;
        end else if ((r_cnt[i] + 4'd1) >= c_FILTER) begin
          w_cnt_nxt[i] = '0;
          w_out_nxt[i] = r_sync2[i];
          w_upd[i]     = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out          <= RESET_VAL;
      r_sample_valid <= 1'b0;
      r_changed      <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_out          <= w_out_nxt;
      r_sample_valid <= w_commit;
      r_changed      <= |w_upd;
      for (int i = 0; i < SIZE; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign out          = r_out;
  assign sample_valid = r_sample_valid;
  assign changed      = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_emulate_pull_resistor.sv
`default_nettype none
// ============================================================================
// Module   : tb_emulate_pull_resistor
// Purpose  : Self-checking bench for emulate_pull_resistor (SIZE=4, default
//            timing, FILTER=2). Models each pin as a node that keeps the
//            level left by the block's drive pulse unless an external driver
//            overrides it, and predicts out/changed per period in a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emulate_pull_resistor;

  localparam int              SIZE    = 4;
  localparam int              DRV     = 1;
  localparam int              STL     = 2;
  localparam int              SMP     = 1;
  localparam int              FILT    = 2;
  localparam int              P       = DRV + STL + SMP;
  localparam logic [SIZE-1:0] RST_VAL = '0;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic [2*SIZE-1:0] pull_mode = '0;
  logic [SIZE-1:0]   out;
  logic              sample_valid;
  logic              changed;
  wire  [SIZE-1:0]   pad;

  // External world: optional strong driver per pin, else the kept level.
  logic [SIZE-1:0]   ext_en  = '0;
  logic [SIZE-1:0]   ext_val = '0;
  logic [SIZE-1:0]   keep    = '0;
  int unsigned       tb_cyc;
  logic              tb_in_drive;
  logic              tb_drv_en;

  int                n_vec = 0;
  int                n_err = 0;
  logic [SIZE-1:0]   m_out;
  int                m_cnt [SIZE];
  logic [SIZE:0]     exp_q [$];

  emulate_pull_resistor #(
    .SIZE          (SIZE),
    .DRIVE_CYCLES  (DRV),
    .SETTLE_CYCLES (STL),
    .SAMPLE_CYCLES (SMP),
    .FILTER        (FILT),
    .RESET_VAL     (RST_VAL)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .pad          (pad),
    .pull_mode    (pull_mode),
    .out          (out),
    .sample_valid (sample_valid),
    .changed      (changed)
  );

  always #5 clk = ~clk;

  // Expected schedule: cycle 0 after release is IDLE, then DRIVE every P.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  assign tb_in_drive = (tb_cyc >= 1) && (((tb_cyc - 1) % P) < DRV);
  assign tb_drv_en   = !rst && (tb_cyc != 0) && !tb_in_drive;

  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_bus
      assign pad[gi] = tb_drv_en ? (ext_en[gi] ? ext_val[gi] : keep[gi]) : 1'bz;
    end
  endgenerate

  // Pin charge: remembers the level seen while the block drives.
  always @(negedge clk) begin
    if (rst) begin
      keep <= '0;
    end else if (tb_in_drive) begin
      for (int i = 0; i < SIZE; i++) keep[i] <= (pad[i] === 1'b1);
    end
  end

  task automatic model_reset;
    m_out = RST_VAL;
    for (int i = 0; i < SIZE; i++) m_cnt[i] = 0;
    exp_q.delete();
  endtask

  // Runs one period. Entered at the negedge just before the DRIVE-entry edge;
  // returns at the negedge of the last SAMPLE cycle.
  task automatic do_period(input logic [2*SIZE-1:0] mode, input logic [SIZE-1:0] een,
                           input logic [SIZE-1:0] evl, input logic [2*SIZE-1:0] mid_mode,
                           input bit rst_in_drive);
    logic [SIZE-1:0] upd;
    logic            smp;
    logic            hi;
    logic [SIZE:0]   exp_prev;
    pull_mode = mode;
    ext_en    = een;
    ext_val   = evl;
    upd       = '0;
    for (int i = 0; i < SIZE; i++) begin
      smp = een[i] ? evl[i] : (mode[2*i +: 2] == 2'b10);
      if (smp == m_out[i]) begin
        m_cnt[i] = 0;
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] >= FILT) begin
          m_out[i] = smp;
          m_cnt[i] = 0;
          upd[i]   = 1'b1;
        end
      end
    end
    exp_q.push_back({|upd, m_out});

    @(posedge clk); @(negedge clk);
    if (exp_q.size() >= 2) begin
      exp_prev = exp_q.pop_front();
      n_vec++;
      if (sample_valid !== 1'b1) begin
        n_err++; $display("FAIL commit_valid: got %b want 1 (t=%0t)", sample_valid, $time);
      end
      n_vec++;
      if (out !== exp_prev[SIZE-1:0]) begin
        n_err++; $display("FAIL commit_out: got %b want %b (t=%0t)", out, exp_prev[SIZE-1:0], $time);
      end
      n_vec++;
      if (changed !== exp_prev[SIZE]) begin
        n_err++; $display("FAIL commit_changed: got %b want %b (t=%0t)", changed, exp_prev[SIZE], $time);
      end
    end else begin
      n_vec++;
      if (sample_valid !== 1'b0 || changed !== 1'b0) begin
        n_err++; $display("FAIL first_drive_pulse: got sv=%b ch=%b want 0 0 (t=%0t)", sample_valid, changed, $time);
      end
    end
    for (int i = 0; i < SIZE; i++) begin
      hi = (mode[2*i +: 2] == 2'b10);
      n_vec++;
      if ((pad[i] === 1'b1) !== hi) begin
        n_err++; $display("FAIL drive_pad%0d: got %b want high=%b (t=%0t)", i, pad[i], hi, $time);
      end
    end

    if (rst_in_drive) begin
      rst = 1'b1;
      #1;
      n_vec++;
      if (pad !== pad || (pad & 4'b1111) != 4'b0000) begin
        n_err++; $display("FAIL rst_pads_release: got %b want no pad high (t=%0t)", pad, $time);
      end
      n_vec++;
      if (out !== RST_VAL || sample_valid !== 1'b0 || changed !== 1'b0) begin
        n_err++; $display("FAIL rst_async_out: got out=%b sv=%b ch=%b want %b 0 0 (t=%0t)",
                          out, sample_valid, changed, RST_VAL, $time);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if ((pad & 4'b1111) != 4'b0000 || sample_valid !== 1'b0) begin
        n_err++; $display("FAIL idle_after_rst: got pad=%b sv=%b want 0000 0 (t=%0t)", pad, sample_valid, $time);
      end
      return;
    end

    for (int c = 1; c < P; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == DRV) pull_mode = mid_mode;
      n_vec++;
      if (sample_valid !== 1'b0 || changed !== 1'b0) begin
        n_err++; $display("FAIL quiet_cycle%0d: got sv=%b ch=%b want 0 0 (t=%0t)", c, sample_valid, changed, $time);
      end
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    pull_mode = 8'hAA;
    repeat (3) @(negedge clk);
    n_vec++;
    if (out !== RST_VAL || sample_valid !== 1'b0 || changed !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got out=%b sv=%b ch=%b want %b 0 0", out, sample_valid, changed, RST_VAL);
    end
    n_vec++;
    if ((pad & 4'b1111) != 4'b0000) begin
      n_err++; $display("FAIL reset_pads: got %b want no pad high", pad);
    end
    model_reset();
    rst = 1'b0;
    #1;
    n_vec++;
    if ((pad & 4'b1111) != 4'b0000 || sample_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_cycle: got pad=%b sv=%b want 0000 0", pad, sample_valid);
    end
  endtask

  task automatic test_pull_down;
    repeat (3) do_period(8'h55, 4'b0000, 4'b0000, 8'h55, 1'b0);
  endtask

  task automatic test_pull_up_override;
    repeat (3) do_period(8'hAA, 4'b0100, 4'b0000, 8'hAA, 1'b0);
  endtask

  task automatic test_glitch;
    repeat (2) do_period(8'h55, 4'b0000, 4'b0000, 8'h55, 1'b0);
    do_period(8'h55, 4'b0001, 4'b0001, 8'h55, 1'b0);
    do_period(8'h55, 4'b0000, 4'b0000, 8'h55, 1'b0);
    do_period(8'h55, 4'b0001, 4'b0001, 8'h55, 1'b0);
    repeat (2) do_period(8'h55, 4'b0000, 4'b0000, 8'h55, 1'b0);
  endtask

  task automatic test_mode_switch;
    do_period(8'h55, 4'b0000, 4'b0000, 8'hAA, 1'b0);
    repeat (3) do_period(8'hAA, 4'b0000, 4'b0000, 8'hAA, 1'b0);
  endtask

  task automatic test_reset_in_drive;
    do_period(8'hAA, 4'b0000, 4'b0000, 8'hAA, 1'b1);
    repeat (3) do_period(8'hAA, 4'b0000, 4'b0000, 8'hAA, 1'b0);
  endtask

  task automatic test_none_modes;
    // ch0 up, ch1 11, ch2 down, ch3 00
    repeat (10) do_period(8'b00_01_11_10, 4'b0000, 4'b0000, 8'b00_01_11_10, 1'b0);
  endtask

  task automatic test_drain;
    logic [SIZE:0] exp_prev;
    @(posedge clk); @(negedge clk);
    n_vec++;
    if (exp_q.size() != 1) begin
      n_err++; $display("FAIL drain_queue: got %0d pending want 1", exp_q.size());
    end else begin
      exp_prev = exp_q.pop_front();
      n_vec++;
      if (sample_valid !== 1'b1 || out !== exp_prev[SIZE-1:0] || changed !== exp_prev[SIZE]) begin
        n_err++; $display("FAIL drain_commit: got sv=%b out=%b ch=%b want 1 %b %b",
                          sample_valid, out, changed, exp_prev[SIZE-1:0], exp_prev[SIZE]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pull_down();
    test_pull_up_override();
    test_glitch();
    test_mode_switch();
    test_reset_in_drive();
    test_none_modes();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/emulate_pull_resistor.md
EMULATE_PULL_RESISTOR -- requirements
Module: emulate_pull_resistor

Interface
REQ-001 Parameter SIZE, 8: number of pad channels.
REQ-002 Parameter DRIVE_CYCLES, 1: cycles per period that pads are actively driven; legal >=1.
REQ-003 Parameter SETTLE_CYCLES, 2: cycles after drive release before sampling; legal >=2.
REQ-004 Parameter SAMPLE_CYCLES, 1: sampling-window length; legal >=1; commit on its last cycle.
REQ-005 Parameter FILTER, 2: consecutive differing samples required to change an output; legal 1..15.
REQ-006 Parameter RESET_VAL, {SIZE{1'b0}}: value of out while rst is asserted.
REQ-007 clk  input  1  single clock, all state updates on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 pad  inout  SIZE  pins being emulated as pulled; driven or high-Z by this block.
REQ-010 pull_mode  input  2*SIZE  per channel [2i+1:2i]: 00 none, 01 pull-down, 10 pull-up, 11 treated as none.
REQ-011 out  output  SIZE  filtered, registered pad values.
REQ-012 sample_valid  output  1  one-cycle pulse on every sample commit.
REQ-013 changed  output  1  one-cycle pulse, same cycle as sample_valid, when any out bit changed at that commit.

Function
REQ-014 FSM states IDLE, DRIVE, SETTLE, SAMPLE; one phase counter shared, cleared on every state transition.
REQ-015 IDLE -> DRIVE on first clk edge after rst deasserts, unconditionally; IDLE lasts exactly one cycle.
REQ-016 DRIVE lasts DRIVE_CYCLES, SETTLE lasts SETTLE_CYCLES, SAMPLE lasts SAMPLE_CYCLES; SAMPLE -> DRIVE; period P = DRIVE_CYCLES+SETTLE_CYCLES+SAMPLE_CYCLES, no gap cycles.
REQ-017 pull_mode captured into a mode register on every edge entering DRIVE; held constant for the whole period; mid-period pull_mode changes take effect next period.
REQ-018 In DRIVE: pad[i] = 0 if captured mode 01, 1 if 10, high-Z if 00/11; all other states: every pad high-Z.
REQ-019 pad passes through a 2-flop synchroniser running every cycle; only synchroniser output is ever sampled.
REQ-020 On the last SAMPLE cycle edge (commit): per channel, if sync[i] == out[i], filter count[i] <= 0; else count[i] increments; when incremented value reaches FILTER, out[i] <= sync[i] and count[i] <= 0 on that same edge.
REQ-021 FILTER = 1: out[i] follows the committed sample at the same commit edge.
REQ-022 Filter counters 4 bits, never exceed FILTER, never wrap.
REQ-023 sample_valid and changed registered; asserted in the cycle following the commit edge, low otherwise; changed = OR of per-channel update at that commit.
REQ-024 Channels fully independent; mode, filter and update of channel i never affect channel j.

Reset
REQ-025 rst asserted: state IDLE, phase counter 0, mode register 00 on all channels (all pads high-Z), synchroniser flops 0, filter counts 0, out = RESET_VAL, sample_valid = 0, changed = 0 -- immediately, without clk.
REQ-026 rst asserted mid-period (any state, including DRIVE): pads go high-Z asynchronously; partial filter progress discarded; after release sequence restarts from IDLE per REQ-015.

Verification
REQ-027 Reset release, SIZE=4, defaults (P=4), pull_mode=01 all, pads undriven externally -> pads 0 for 1 cycle every 4 starting second cycle after release; out stays 0; sample_valid pulses every 4 cycles; changed never.
REQ-028 Pull-up mode 10 all, channel 2 externally driven 0, FILTER=2 -> out = 4'b1011 after second commit, changed pulses once at that commit; earlier commit: sample_valid only.
REQ-029 FILTER=2, channel 0 external glitch high for exactly one commit, else pulled down -> out[0] stays 0; count[0] returns to 0; changed never pulses.
REQ-030 pull_mode switched 01->10 in mid-SETTLE -> current period unchanged; next DRIVE drives 1s; undriven pads reach out=1 after FILTER further commits.
REQ-031 rst asserted during DRIVE with pull_mode=10 -> pads high-Z same cycle, out = RESET_VAL; after release, one IDLE cycle, then DRIVE at full DRIVE_CYCLES.
REQ-032 pull_mode=11 and 00 on channels 1,3, no external drive -> those pads never driven by block across 10 periods; other channels unaffected.
